// File: rtl/maze_memory_if.sv
// Maze memory bus: row-load front end plus the rat's cell read/write port.
interface maze_memory_if;
    logic        LdStart;
    logic        LdValid;
    logic [15:0] LdRow;
    logic        LdBusy;
    logic        LdDone;
    logic        Ready;
    logic        RD;
    logic        WR;
    logic        Din;
    logic [3:0]  X;
    logic [3:0]  Y;
    logic        Dout;
    logic [7:0]  WrCount;

    modport master (
        output LdStart, LdValid, LdRow, RD, WR, Din, X, Y,
        input  LdBusy, LdDone, Ready, Dout, WrCount
    );

    modport slave (
        input  LdStart, LdValid, LdRow, RD, WR, Din, X, Y,
        output LdBusy, LdDone, Ready, Dout, WrCount
    );
endinterface

// File: rtl/maze_memory.sv
// 16x16 bit-cell maze store: row loader front end, then rat read/write service.
// Reads are registered (1 cycle); writes are counted, saturating at 255.
module maze_memory (
    input  logic   CLK,
    input  logic   RST,
    maze_memory_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        r;
    logic [15:0][15:0] mem;
    logic              dout;
    logic              lddone;
    logic [7:0]        wrcount;

    assign bus.LdBusy  = (state == LOAD);
    assign bus.Ready   = (state == READY);
    assign bus.LdDone  = lddone;
    assign bus.Dout    = dout;
    assign bus.WrCount = wrcount;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            r       <= 4'd0;
            mem     <= '0;
            dout    <= 1'b1;
            lddone  <= 1'b0;
            wrcount <= 8'd0;
        end else begin
            lddone <= 1'b0;
            // Reads see the pre-write cell; outside READY every cell looks blocked.
            if (bus.RD)
                dout <= (state == READY) ? mem[bus.Y][bus.X] : 1'b1;
            if (bus.LdStart) begin
                state   <= LOAD;
                r       <= 4'd0;
                wrcount <= 8'd0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (bus.LdValid) begin
                            mem[r] <= bus.LdRow;
                            r      <= r + 4'd1;
                            if (r == 4'd15) begin
                                state  <= READY;
                                lddone <= 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (bus.WR) begin
                            mem[bus.Y][bus.X] <= bus.Din;
                            if (wrcount != 8'hff)
                                wrcount <= wrcount + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
